test_1: RTL and testbench
=========================

# test_1

Frame-diff scanner for the snake game's image generator. It walks a 16×12 tile grid in raster order, encodes the object at the current tile into a 3-bit code, and compares it with the code stored for that tile in the previous frame. Changed tiles, and every tile of the first frame, are handed to the display command block through an `en_update`/`cmd_done` handshake. The block sits between the game-state logic, which supplies the per-tile object flags, and the LCD command sequencer.

## Interface
Parameters (fixed constants, not overridable):
- GRID_W, 16, tile columns (x 0..15)
- GRID_H, 12, tile rows (y 0..11)

Ports:
- clk  in  1  system clock; all logic rising-edge
- nrst  in  1  reset, asynchronous, active-low
- clk2  in  1  reserved, unused; integrators tie it to clk
- snakeHead  in  1  current tile holds the snake head
- snakeBody  in  1  current tile holds a snake body segment
- apple  in  1  current tile holds the apple
- border  in  1  current tile is a wall
- mode_pb  in  1  restart button, synchronous single-cycle pulse
- GameOver  in  1  game-over level from game logic
- cmd_done  in  1  display finished the requested tile; single-cycle pulse
- x  out  4  current tile column
- y  out  4  current tile row
- obj_code  out  3  encoded object at (x,y)
- diff  out  1  current tile differs from the stored frame, or init_cycle=1
- en_update  out  1  request to draw tile (x,y) with obj_code
- enable_loop  out  1  scanner is free-running (SCAN state)
- init_cycle  out  1  first full-frame draw in progress
- sync_reset  out  1  one-cycle restart pulse to the rest of the game

## Operation
- obj_code is combinational, with priority head > body > apple > border > empty.
  - head = 001, body = 010, apple = 011, border = 100, empty = 000.
  - Codes 101–111 are never produced.
- Frame memory holds 192 × 3-bit entries, indexed y*16+x. Reset clears every entry to 000.
- State machine:
  - START: after reset. enable_loop=0, init_cycle=1. Waits for cmd_done (display init complete), then goes to SCAN.
  - SCAN: enable_loop=1. diff = init_cycle | (obj_code != mem[x][y]).
    - diff=0: advance to the next tile this clock.
    - diff=1: go to WAIT; (x,y) holds.
  - WAIT: en_update=1, enable_loop=0; (x,y) and diff are held. On cmd_done: write mem[x][y] ← obj_code, advance the tile, return to SCAN.
- Advance rule:
  - x increments.
  - At x=15: x←0 and y increments.
  - At (15,11): wrap to (0,0) and clear init_cycle.
- Restart: mode_pb=1 while GameOver=1 produces the following on the next edge:
  - sync_reset=1 for exactly one cycle.
  - (x,y)←(0,0), init_cycle←1, state←SCAN.
  - Frame memory is not cleared, because init_cycle forces a full redraw.
- mode_pb with GameOver=0 is ignored.
- A cmd_done arriving outside START or WAIT is ignored.

## Timing
- Reset values: x=0, y=0, obj_code=encode(inputs), diff=0, en_update=0, enable_loop=0, init_cycle=1, sync_reset=0, state=START.
- Unchanged tile: 1 cycle per tile.
- Changed tile:
  - diff is high in the SCAN cycle.
  - en_update rises the next cycle and stays high until the edge that samples cmd_done.
  - New (x,y) appears the cycle after cmd_done.
- The object inputs must stay stable for the tile while en_update=1. The memory write uses obj_code at the cmd_done edge.
- Restart has priority over everything, including a simultaneous cmd_done. That cmd_done is dropped and no memory write occurs.
- Asynchronous reset mid-WAIT aborts the request: en_update drops immediately.

## Structure
- Package test_1_pkg:
  - obj_code localparams (OBJ_EMPTY, OBJ_HEAD, OBJ_BODY, OBJ_APPLE, OBJ_BORDER).
  - GRID_W and GRID_H.
  - State enum {START, SCAN, WAIT}.
- Sub-module obj_encoder: the combinational priority encoder for obj_code.
- The frame memory is an inferred register array inside test_1.

## Test plan
- Reset: nrst low 2 cycles, then wait 5 cycles → x=0, y=0, init_cycle=1, enable_loop=0, en_update=0.
- First frame:
  - Stimulus: pulse cmd_done, then pulse cmd_done each time en_update=1.
  - Required: all 192 tiles request an update, visited in raster order.
  - Required: after tile (15,11) is acknowledged, (x,y)=(0,0) and init_cycle=0.
- Second frame, unchanged inputs → no en_update; enable_loop=1 continuously; the scan takes 192 cycles.
- Change tile (4,4) from empty to head → only (4,4) raises diff/en_update with obj_code=001. The scanner stalls there until cmd_done, then resumes at (5,4).
- Encoding priority: at one tile, drive apple=1 and border=1 → obj_code=011. Drive all four flags → obj_code=001.
- Restart: GameOver=1 plus a mode_pb pulse mid-scan → sync_reset high for exactly 1 cycle, (x,y)=(0,0), init_cycle=1. The same pulse with GameOver=0 → no effect.

Source files
------------

// File: rtl/test_1_pkg.sv
// Shared constants and types for the frame-diff tile scanner.
package test_1_pkg;

    localparam int unsigned GRID_W = 16;
    localparam int unsigned GRID_H = 12;
    localparam int unsigned TILES  = GRID_W * GRID_H;

    localparam logic [2:0] OBJ_EMPTY  = 3'b000;
    localparam logic [2:0] OBJ_HEAD   = 3'b001;
    localparam logic [2:0] OBJ_BODY   = 3'b010;
    localparam logic [2:0] OBJ_APPLE  = 3'b011;
    localparam logic [2:0] OBJ_BORDER = 3'b100;

    typedef enum logic [1:0] {
        START,
        SCAN,
        WAIT
    } state_t;

    // y*16+x; GRID_W is a power of two so the row simply forms the upper bits
    function automatic logic [7:0] tile_index(input logic [3:0] col, input logic [3:0] row);
        return {row, col};
    endfunction

endpackage

// File: rtl/test_1_obj_encoder.sv
// Priority encoder from per-tile object flags to the 3-bit object code.
module obj_encoder
    import test_1_pkg::*;
(
    input  logic       snake_head,
    input  logic       snake_body,
    input  logic       apple,
    input  logic       border,
    output logic [2:0] obj_code
);

    always_comb begin
        obj_code = OBJ_EMPTY;
        if (snake_head) begin
            obj_code = OBJ_HEAD;
        end else if (snake_body) begin
            obj_code = OBJ_BODY;
        end else if (apple) begin
            obj_code = OBJ_APPLE;
        end else if (border) begin
            obj_code = OBJ_BORDER;
        end
    end

endmodule

// File: rtl/test_1.sv
// Frame-diff scanner: walks the tile grid, compares each tile with the previous
// frame and requests a display update for every changed tile.
module test_1
    import test_1_pkg::*;
(
    input  logic       clk,
    input  logic       nrst,
    input  logic       clk2,
    input  logic       snakeHead,
    input  logic       snakeBody,
    input  logic       apple,
    input  logic       border,
    input  logic       mode_pb,
    input  logic       GameOver,
    input  logic       cmd_done,
    output logic [3:0] x,
    output logic [3:0] y,
    output logic [2:0] obj_code,
    output logic       diff,
    output logic       en_update,
    output logic       enable_loop,
    output logic       init_cycle,
    output logic       sync_reset
);

    localparam logic [3:0] X_LAST = 4'(GRID_W - 1);
    localparam logic [3:0] Y_LAST = 4'(GRID_H - 1);

    state_t     state;
    state_t     state_nxt;
    logic [3:0] x_nxt;
    logic [3:0] y_nxt;
    logic       init_nxt;
    logic [3:0] adv_x;
    logic [3:0] adv_y;
    logic       adv_init;
    logic       restart;
    logic       mem_we;
    logic       tile_changed;
    logic [2:0] stored_code;
    logic [2:0] frame_mem [TILES];
    logic       unused_clk2;

    assign unused_clk2 = clk2;

    obj_encoder u_obj_encoder (
        .snake_head (snakeHead),
        .snake_body (snakeBody),
        .apple      (apple),
        .border     (border),
        .obj_code   (obj_code)
    );

    assign restart      = mode_pb & GameOver;
    assign stored_code  = frame_mem[tile_index(x, y)];
    assign tile_changed = init_cycle | (obj_code != stored_code);

    // Raster-order successor of (x,y); wrapping the frame ends the initial redraw
    always_comb begin
        adv_x    = x + 4'd1;
        adv_y    = y;
        adv_init = init_cycle;
        if (x == X_LAST) begin
            adv_x = '0;
            if (y == Y_LAST) begin
                adv_y    = '0;
                adv_init = 1'b0;
            end else begin
                adv_y = y + 4'd1;
            end
        end
    end

    always_comb begin
        state_nxt   = state;
        x_nxt       = x;
        y_nxt       = y;
        init_nxt    = init_cycle;
        mem_we      = 1'b0;
        diff        = 1'b0;
        en_update   = 1'b0;
        enable_loop = 1'b0;

        case (state)
            START: begin
                if (cmd_done) begin
                    state_nxt = SCAN;
                end
            end
            SCAN: begin
                enable_loop = 1'b1;
                diff        = tile_changed;
                if (tile_changed) begin
                    state_nxt = WAIT;
                end else begin
                    x_nxt    = adv_x;
                    y_nxt    = adv_y;
                    init_nxt = adv_init;
                end
            end
            WAIT: begin
                en_update = 1'b1;
                diff      = 1'b1;
                if (cmd_done) begin
                    mem_we    = 1'b1;
                    state_nxt = SCAN;
                    x_nxt     = adv_x;
                    y_nxt     = adv_y;
                    init_nxt  = adv_init;
                end
            end
            default: begin
                state_nxt = START;
            end
        endcase

        // Restart overrides any handshake completing on the same edge
        if (restart) begin
            state_nxt = SCAN;
            x_nxt     = '0;
            y_nxt     = '0;
            init_nxt  = 1'b1;
            mem_we    = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            state      <= START;
            x          <= '0;
            y          <= '0;
            init_cycle <= 1'b1;
            sync_reset <= 1'b0;
        end else begin
            state      <= state_nxt;
            x          <= x_nxt;
            y          <= y_nxt;
            init_cycle <= init_nxt;
            sync_reset <= restart;
        end
    end

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            for (int unsigned i = 0; i < TILES; i++) begin
                frame_mem[8'(i)] <= OBJ_EMPTY;
            end
        end else if (mem_we) begin
            frame_mem[tile_index(x, y)] <= obj_code;
        end
    end

endmodule

// File: tb/tb_test_1.sv
// Randomized bench for test_1 against a frame-level model of the tile grid.
module tb_test_1;

    logic       clk = 1'b0;
    logic       nrst;
    logic       snakeHead, snakeBody, apple, border;
    logic       mode_pb, GameOver, cmd_done;
    logic [3:0] x, y;
    logic [2:0] obj_code;
    logic       diff, en_update, enable_loop, init_cycle, sync_reset;

    always #5 clk = ~clk;

    test_1 dut (
        .clk         (clk),
        .nrst        (nrst),
        .clk2        (clk),
        .snakeHead   (snakeHead),
        .snakeBody   (snakeBody),
        .apple       (apple),
        .border      (border),
        .mode_pb     (mode_pb),
        .GameOver    (GameOver),
        .cmd_done    (cmd_done),
        .x           (x),
        .y           (y),
        .obj_code    (obj_code),
        .diff        (diff),
        .en_update   (en_update),
        .enable_loop (enable_loop),
        .init_cycle  (init_cycle),
        .sync_reset  (sync_reset)
    );

    int         n_cmp = 0;
    int         n_bad = 0;
    logic [3:0] world   [192];   // {head, body, apple, border} per tile
    logic [2:0] ref_mem [192];   // what the display currently shows
    bit         ref_init;
    int         ack_q [$];       // observed acks: position*8 + code
    bit         ab;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    function automatic int encode(input logic [3:0] f);
        if (f[3]) return 1;
        if (f[2]) return 2;
        if (f[1]) return 3;
        if (f[0]) return 4;
        return 0;
    endfunction

    function automatic logic [3:0] random_flags();
        int r;
        r = $urandom_range(0, 9);
        case (r)
            0: return 4'b1000;
            1: return 4'b0100;
            2: return 4'b0010;
            3: return 4'b0001;
            4: return 4'($urandom);
            default: return 4'b0000;
        endcase
    endfunction

    function automatic int dut_pos();
        return int'(y) * 16 + int'(x);
    endfunction

    task automatic drive_tile();
        int p;
        p = dut_pos();
        if (p < 192) {snakeHead, snakeBody, apple, border} = world[p];
        else         {snakeHead, snakeBody, apple, border} = 4'b0000;
    endtask

    task automatic mutate(input int n);
        for (int i = 0; i < n; i++) world[$urandom_range(0, 191)] = random_flags();
    endtask

    task automatic force_change();
        int t;
        t = $urandom_range(0, 191);
        world[t] = (encode(world[t]) == 1) ? 4'b0100 : 4'b1000;
    endtask

    // One frame from (0,0) in scan. abort_at: cycle index for a mode_pb pulse,
    // -2 = pulse together with the first cmd_done, -1 = none.
    task automatic run_frame(input int exp_sync, input int abort_at, input bit go, output bit aborted);
        int  exp_pos[$];
        int  exp_code[$];
        int  delays[$];
        int  total, k, wcnt, nscan, ndiff, nsync, code, d, epos, ecode;
        bit  ack_now, pulsed;
        ack_q.delete();
        aborted = 1'b0;
        total = 192;
        for (int t = 0; t < 192; t++) begin
            code = encode(world[t]);
            if (ref_init || code != int'(ref_mem[t])) begin
                d = $urandom_range(0, 3);
                exp_pos.push_back(t);
                exp_code.push_back(code);
                delays.push_back(d);
                total += d + 1;
            end
        end
        k = 0; wcnt = 0; nscan = 0; ndiff = 0; nsync = 0; epos = 0; ecode = 0;
        for (int c = 0; c < total; c++) begin
            @(negedge clk);
            drive_tile();
            #1;
            nsync += int'(sync_reset);
            nscan += int'(enable_loop);
            ndiff += int'(diff);
            ack_now  = 1'b0;
            pulsed   = 1'b0;
            cmd_done = 1'b0;
            mode_pb  = 1'b0;
            GameOver = 1'($urandom_range(0, 1));
            if (en_update) begin
                d = (k < exp_pos.size()) ? delays[k] : 0;
                if (wcnt >= d) begin
                    ack_now  = 1'b1;
                    wcnt     = 0;
                    cmd_done = 1'b1;
                    ack_q.push_back(dut_pos() * 8 + int'(obj_code));
                    if (k < exp_pos.size()) begin
                        epos  = exp_pos[k];
                        ecode = exp_code[k];
                        check("ack", dut_pos() * 16 + int'(obj_code) * 2 + int'(diff), epos * 16 + ecode * 2 + 1);
                    end else begin
                        epos  = dut_pos();
                        ecode = int'(obj_code);
                        check("ack_unexpected", dut_pos(), 32'hFFFF_FFFF);
                    end
                end else begin
                    wcnt++;
                end
            end else if ($urandom_range(0, 7) == 0) begin
                cmd_done = 1'b1;
            end
            if (c == abort_at || (abort_at == -2 && ack_now)) begin
                mode_pb  = 1'b1;
                GameOver = go;
                pulsed   = 1'b1;
            end
            @(posedge clk);
            #1;
            cmd_done = 1'b0;
            mode_pb  = 1'b0;
            if (pulsed && go) begin
                check("restart_ctl", {29'd0, sync_reset, init_cycle, en_update}, 6);
                check("restart_pos", dut_pos(), 0);
                ref_init = 1'b1;
                aborted  = 1'b1;
                return;
            end
            if (ack_now) begin
                ref_mem[epos] = 3'(ecode);
                k++;
                check("next_tile", dut_pos(), (epos + 1) % 192);
            end
        end
        check("frame_end_pos", dut_pos(), 0);
        check("frame_end_init", init_cycle, 0);
        check("ack_count", k, exp_pos.size());
        check("scan_cycles", nscan, 192);
        check("diff_cycles", ndiff, total - 192 + exp_pos.size());
        check("sync_pulses", nsync, exp_sync);
        ref_init = 1'b0;
    endtask

    initial begin
        #1_000_000;
        n_bad++;
        $display("FAIL watchdog: got timeout expected finish");
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $fatal(1, "timeout");
    end

    initial begin
        nrst = 1'b0; cmd_done = 1'b0; mode_pb = 1'b0; GameOver = 1'b0;
        {snakeHead, snakeBody, apple, border} = 4'b0011;
        for (int t = 0; t < 192; t++) begin
            world[t]   = random_flags();
            ref_mem[t] = 3'd0;
        end
        world[68] = 4'b0000; world[100] = 4'b0000; world[101] = 4'b0000;
        ref_init = 1'b1;

        // Reset and idle in START
        repeat (2) @(posedge clk);
        @(negedge clk) nrst = 1'b1;
        repeat (5) @(negedge clk);
        #1;
        check("rst_pos", dut_pos(), 0);
        check("rst_init", init_cycle, 1);
        check("rst_enable_loop", enable_loop, 0);
        check("rst_en_update", en_update, 0);
        check("rst_diff", diff, 0);
        check("rst_sync", sync_reset, 0);
        check("rst_obj_code", obj_code, 3);

        @(negedge clk) cmd_done = 1'b1;
        @(posedge clk);
        #1 cmd_done = 1'b0;
        check("start_exit", enable_loop, 1);

        run_frame(0, -1, 1'b0, ab);
        check("first_frame_updates", ack_q.size(), 192);

        run_frame(0, -1, 1'b0, ab);
        check("quiet_frame_updates", ack_q.size(), 0);

        world[68] = 4'b1000;
        run_frame(0, -1, 1'b0, ab);
        check("head_count", ack_q.size(), 1);
        if (ack_q.size() >= 1) check("head_ack", ack_q[0], 68 * 8 + 1);

        world[100] = 4'b0011;
        world[101] = 4'b1111;
        run_frame(0, -1, 1'b0, ab);
        check("prio_count", ack_q.size(), 2);
        if (ack_q.size() >= 2) begin
            check("prio_apple_border", ack_q[0], 100 * 8 + 3);
            check("prio_all_flags", ack_q[1], 101 * 8 + 1);
        end

        repeat (3) begin
            mutate(12);
            run_frame(0, -1, 1'b0, ab);
        end

        mutate(8);
        run_frame(0, $urandom_range(10, 150), 1'b0, ab);
        check("ignored_restart", ab, 0);

        mutate(8);
        run_frame(0, $urandom_range(20, 180), 1'b1, ab);
        check("restart_taken", ab, 1);
        run_frame(1, -1, 1'b0, ab);
        check("redraw_updates", ack_q.size(), 192);
        run_frame(0, -1, 1'b0, ab);
        check("post_redraw_quiet", ack_q.size(), 0);

        force_change();
        run_frame(0, -2, 1'b1, ab);
        check("restart_on_ack", ab, 1);
        run_frame(1, -1, 1'b0, ab);
        run_frame(0, -1, 1'b0, ab);
        check("post_ack_restart_quiet", ack_q.size(), 0);

        // Asynchronous reset while a request is outstanding
        force_change();
        for (int c = 0; c < 400; c++) begin
            @(negedge clk);
            drive_tile();
            #1;
            if (en_update) break;
        end
        check("wait_reached", en_update, 1);
        #2 nrst = 1'b0;
        #1;
        check("async_abort_ctl", {29'd0, en_update, enable_loop, init_cycle}, 1);
        check("async_abort_pos", dut_pos(), 0);
        @(negedge clk) nrst = 1'b1;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
